// File: rtl/led16_pkg.sv
// ---------------------------------------------------------------------------
// led16_pkg
// Shared definitions for the 16-LED pattern controller:
//   - LED_W           : width of the LED image (one bit per LED)
//   - OP_*            : 3-bit command opcodes
//   - ST_*            : FSM state encoding
//   - bar_image()     : bar-graph image for a 5-bit level (clamped to 16)
//   - is_timed()      : 1 for states that advance on the prescaled tick
// ---------------------------------------------------------------------------
package led16_pkg;

    localparam int LED_W = 16;

    // Command opcodes
    localparam logic [2:0] OP_OFF    = 3'b000;
    localparam logic [2:0] OP_STATIC = 3'b001;
    localparam logic [2:0] OP_BLINK  = 3'b010;
    localparam logic [2:0] OP_SCRL_L = 3'b011;
    localparam logic [2:0] OP_SCRL_R = 3'b100;
    localparam logic [2:0] OP_BAR    = 3'b101;
    localparam logic [2:0] OP_XOR    = 3'b110;
    localparam logic [2:0] OP_RSVD   = 3'b111;

    // FSM state encoding
    localparam logic [2:0] ST_OFF       = 3'd0;
    localparam logic [2:0] ST_STATIC    = 3'd1;
    localparam logic [2:0] ST_BLINK_ON  = 3'd2;
    localparam logic [2:0] ST_BLINK_OFF = 3'd3;
    localparam logic [2:0] ST_SCROLL_L  = 3'd4;
    localparam logic [2:0] ST_SCROLL_R  = 3'd5;

    // Bar graph: the lowest lvl LEDs lit; levels above 16 saturate at all-on.
    // The shift is done 17 bits wide so lvl=16 yields 16'hFFFF after the -1.
    function automatic logic [LED_W-1:0] bar_image(input logic [4:0] lvl_raw);
        logic [4:0]  lvl;
        logic [16:0] wide;
        lvl  = (lvl_raw > 5'd16) ? 5'd16 : lvl_raw;
        wide = (17'h1 << lvl) - 17'h1;
        return wide[LED_W-1:0];
    endfunction

    function automatic logic is_timed(input logic [2:0] st);
        return (st == ST_BLINK_ON) || (st == ST_BLINK_OFF) ||
               (st == ST_SCROLL_L) || (st == ST_SCROLL_R);
    endfunction

endpackage

// File: rtl/led16_tick_gen.sv
// ---------------------------------------------------------------------------
// led16_tick_gen
// Prescaler: counts 0..TICK_DIV-1 while enabled and emits a one-cycle tick
// in the cycle the counter sits at its last value (the wrap cycle).
// Ports:
//   clk   in  1  system clock
//   rst   in  1  synchronous reset, active-high
//   en    in  1  count enable (held value when low)
//   clr   in  1  synchronous clear back to 0 (wins over en)
//   tick  out 1  wrap pulse, only while en=1
// ---------------------------------------------------------------------------
module led16_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    assign tick = en && (cnt_r == CNT_LAST);

    // Prescale counter with explicit wrap so non-power-of-two dividers work
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= tick ? {CNT_W{1'b0}} : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/led16_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// led16_pattern_ctrl
// Owns the 16-bit LED image for the 4x4 matrix scanner. Commands arrive on a
// valid/ready port; static, blink, scroll-left/right and bar-graph images are
// produced, with time-based modes stepping on a prescaled tick.
// Ports:
//   clk        in  1   system clock
//   rst        in  1   synchronous reset, active-high
//   cmd_valid  in  1   command present
//   cmd_ready  out 1   command can be accepted (1 whenever out of reset)
//   cmd_op     in  3   opcode (OP_* in led16_pkg)
//   cmd_data   in  16  pattern / level operand
//   ledbits    out 16  registered image, bit n = LED n
//   busy       out 1   registered, 1 while blink/scroll is active
// ---------------------------------------------------------------------------
module led16_pattern_ctrl
    import led16_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int BLINK_TICKS  = 250,
    parameter int SCROLL_TICKS = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [LED_W-1:0] cmd_data,
    output logic [LED_W-1:0] ledbits,
    output logic             busy
);

    localparam int STEP_MAX = (BLINK_TICKS > SCROLL_TICKS) ? BLINK_TICKS : SCROLL_TICKS;
    localparam int STEP_W   = $clog2(STEP_MAX + 1);

    logic [2:0]       state_r,   state_n;
    logic [LED_W-1:0] pattern_r, pattern_n;
    logic [LED_W-1:0] ledbits_r, ledbits_n;
    logic [STEP_W-1:0] step_cnt_r, step_cnt_n;
    logic [STEP_W-1:0] step_limit_s;
    logic             busy_r;
    logic             ready_r;
    logic             accept_s;
    logic             restart_s;
    logic             timed_s;
    logic             tick_s;
    logic             step_s;

    assign accept_s  = cmd_valid && ready_r;
    // XOR and reserved leave the mode's phase untouched
    assign restart_s = accept_s && (cmd_op != OP_XOR) && (cmd_op != OP_RSVD);
    assign timed_s   = is_timed(state_r);

    assign cmd_ready = ready_r;
    assign ledbits   = ledbits_r;
    assign busy      = busy_r;

    led16_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (timed_s),
        .clr  (restart_s),
        .tick (tick_s)
    );

    // Ticks per step for the current mode
    always_comb begin
        case (state_r)
            ST_BLINK_ON, ST_BLINK_OFF: step_limit_s = STEP_W'(BLINK_TICKS - 1);
            ST_SCROLL_L, ST_SCROLL_R:  step_limit_s = STEP_W'(SCROLL_TICKS - 1);
            default:                   step_limit_s = {STEP_W{1'b0}};
        endcase
    end

    assign step_s = tick_s && (step_cnt_r == step_limit_s);

    // Step counter next value
    always_comb begin
        step_cnt_n = step_cnt_r;
        if (restart_s) begin
            step_cnt_n = {STEP_W{1'b0}};
        end else if (tick_s) begin
            step_cnt_n = step_s ? {STEP_W{1'b0}} : step_cnt_r + {{(STEP_W-1){1'b0}}, 1'b1};
        end else begin
            step_cnt_n = step_cnt_r;
        end
    end

    // FSM / image next-state: an accepted command overrides a coincident step
    always_comb begin
        state_n   = state_r;
        pattern_n = pattern_r;
        ledbits_n = ledbits_r;
        if (accept_s) begin
            case (cmd_op)
                OP_OFF: begin
                    state_n   = ST_OFF;
                    ledbits_n = {LED_W{1'b0}};
                end
                OP_STATIC: begin
                    state_n   = ST_STATIC;
                    pattern_n = cmd_data;
                    ledbits_n = cmd_data;
                end
                OP_BLINK: begin
                    state_n   = ST_BLINK_ON;
                    pattern_n = cmd_data;
                    ledbits_n = cmd_data;
                end
                OP_SCRL_L: begin
                    state_n   = ST_SCROLL_L;
                    pattern_n = cmd_data;
                    ledbits_n = cmd_data;
                end
                OP_SCRL_R: begin
                    state_n   = ST_SCROLL_R;
                    pattern_n = cmd_data;
                    ledbits_n = cmd_data;
                end
                OP_BAR: begin
                    state_n   = ST_STATIC;
                    ledbits_n = bar_image(cmd_data[4:0]);
                end
                OP_XOR: begin
                    pattern_n = pattern_r ^ cmd_data;
                    // The dark half of a blink stays dark; the new pattern
                    // shows up on the next ON phase.
                    if (state_r == ST_BLINK_OFF) begin
                        ledbits_n = ledbits_r;
                    end else begin
                        ledbits_n = ledbits_r ^ cmd_data;
                    end
                end
                default: begin
                    state_n = state_r;
                end
            endcase
        end else if (step_s) begin
            case (state_r)
                ST_BLINK_ON: begin
                    state_n   = ST_BLINK_OFF;
                    ledbits_n = {LED_W{1'b0}};
                end
                ST_BLINK_OFF: begin
                    state_n   = ST_BLINK_ON;
                    ledbits_n = pattern_r;
                end
                ST_SCROLL_L: begin
                    pattern_n = {pattern_r[LED_W-2:0], pattern_r[LED_W-1]};
                    ledbits_n = {pattern_r[LED_W-2:0], pattern_r[LED_W-1]};
                end
                ST_SCROLL_R: begin
                    pattern_n = {pattern_r[0], pattern_r[LED_W-1:1]};
                    ledbits_n = {pattern_r[0], pattern_r[LED_W-1:1]};
                end
                default: begin
                    state_n = state_r;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // State, image, counters and handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_OFF;
            pattern_r  <= {LED_W{1'b0}};
            ledbits_r  <= {LED_W{1'b0}};
            step_cnt_r <= {STEP_W{1'b0}};
            busy_r     <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            state_r    <= state_n;
            pattern_r  <= pattern_n;
            ledbits_r  <= ledbits_n;
            step_cnt_r <= step_cnt_n;
            busy_r     <= is_timed(state_n);
            ready_r    <= 1'b1;
        end
    end

endmodule
